// File: rtl/int_ctrl_8.sv
// Eight-input prioritised interrupt controller for the 8086 bus.
// Handles edge capture, masking, in-service nesting and the two-pulse INTA vector handshake.
module int_ctrl_8 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [4:0]  RESET_BASE  = 5'b00010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq,
  input  logic       csN,
  input  logic       rdN,
  input  logic       wrN,
  input  logic [1:0] addr,
  input  logic       intaN,
  output logic       intr,
  inout  wire  [7:0] data
);

  localparam int unsigned IrqW = 8;

  typedef enum logic [1:0] {Idle, Ack1, Wait2, Ack2} stateT;

  stateT                               state;
  logic [SYNC_STAGES-1:0][IrqW-1:0]    syncQ;
  logic [IrqW-1:0]                     irqLast;
  logic [IrqW-1:0]                     irr;
  logic [IrqW-1:0]                     isr;
  logic [IrqW-1:0]                     imr;
  logic [4:0]                          base;
  logic [2:0]                          idx;
  logic                                wrQ;
  logic                                wrPrev;
  logic [1:0]                          addrQ;
  logic [IrqW-1:0]                     dataQ;
  logic                                intaQ;
  logic                                intaPrev;

  logic [IrqW-1:0] irqEdge;
  logic [IrqW-1:0] pend;
  logic [IrqW-1:0] qualMask;
  logic [IrqW-1:0] qual;
  logic [IrqW-1:0] ackSet;
  logic [IrqW-1:0] ackClr;
  logic [IrqW-1:0] isrAfterEoi;
  logic [2:0]      selIdx;
  logic            intaFall;
  logic            wrAct;
  logic            eoi;
  logic            ackFire;
  logic [IrqW-1:0] rdData;
  logic            driveVec;
  logic            driveRd;

  // Priority qualification: only requests above the lowest in-service level may interrupt.
  always_comb begin
    irqEdge     = syncQ[SYNC_STAGES-1] & ~irqLast;
    pend        = irr & ~imr;
    qualMask    = (isr & (~isr + 8'd1)) - 8'd1;
    qual        = pend & qualMask;
    ackSet      = qual & (~qual + 8'd1);
    selIdx      = (qual == '0) ? 3'd7
                : {|(ackSet & 8'hF0), |(ackSet & 8'hCC), |(ackSet & 8'hAA)};
    intaFall    = intaPrev & ~intaQ;
    wrAct       = wrQ & ~wrPrev;
    eoi         = wrAct && (addrQ == 2'd3);
    isrAfterEoi = eoi ? (isr & (isr - 8'd1)) : isr;
    ackFire     = (state == Idle) && intaFall;
    ackClr      = ackFire ? ackSet : '0;
  end

  always_comb begin
    rdData = '0;
    case (addr)
      2'd0:    rdData = imr;
      2'd1:    rdData = {base, 3'b000};
      2'd2:    rdData = irr;
      default: rdData = isr;
    endcase
  end

  // The vector wins over a concurrent register read.
  assign driveVec = (state == Ack2) && !intaN;
  assign driveRd  = !csN && !rdN;
  assign data     = driveVec ? {base, idx} : (driveRd ? rdData : 8'bz);

  always_ff @(posedge clk) begin
    if (reset) begin
      // Edge history resets high so a line held high through reset is not seen as a new edge.
      syncQ    <= '1;
      irqLast  <= '1;
      irr      <= '0;
      isr      <= '0;
      imr      <= '1;
      base     <= RESET_BASE;
      idx      <= 3'd7;
      wrQ      <= 1'b0;
      wrPrev   <= 1'b0;
      addrQ    <= '0;
      dataQ    <= '0;
      intaQ    <= 1'b1;
      intaPrev <= 1'b1;
      state    <= Idle;
      intr     <= 1'b0;
    end else begin
      syncQ    <= {syncQ[SYNC_STAGES-2:0], irq};
      irqLast  <= syncQ[SYNC_STAGES-1];
      wrQ      <= !csN && !wrN;
      wrPrev   <= wrQ;
      intaQ    <= intaN;
      intaPrev <= intaQ;
      if (!csN && !wrN) begin
        addrQ <= addr;
        dataQ <= data;
      end

      irr <= (irr & ~ackClr) | irqEdge;
      isr <= isrAfterEoi | ackClr;

      if (wrAct) begin
        case (addrQ)
          2'd0:    imr  <= dataQ;
          2'd1:    base <= dataQ[7:3];
          default: ;
        endcase
      end

      case (state)
        Idle: begin
          if (intaFall) begin
            state <= Ack1;
            idx   <= selIdx;
            intr  <= 1'b0;
          end else begin
            intr <= |qual;
          end
        end
        Ack1: begin
          intr <= 1'b0;
          if (intaQ) state <= Wait2;
        end
        Wait2: begin
          intr <= 1'b0;
          if (intaFall) state <= Ack2;
        end
        Ack2: begin
          if (intaQ) begin
            state <= Idle;
            intr  <= |qual;
          end else begin
            intr <= 1'b0;
          end
        end
        default: begin
          state <= Idle;
          intr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl_8.sv
// Self-checking bench for int_ctrl_8: directed scenarios plus randomized traffic
// checked against a register-level behavioural model.
module tb_int_ctrl_8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq;
  logic       csN;
  logic       rdN;
  logic       wrN;
  logic [1:0] addr;
  logic       intaN;
  logic       intr;
  wire  [7:0] data;
  logic [7:0] dataDrv;
  logic       dataOe;

  int checks = 0;
  int errors = 0;

  logic [7:0] mImr;
  logic [7:0] mIrr;
  logic [7:0] mIsr;
  logic [4:0] mBase;

  // Undriven bus reads back as 0xFF.
  for (genvar g = 0; g < 8; g++) begin : gPull
    pullup (data[g]);
  end
  assign data = dataOe ? dataDrv : 8'bz;

  always #5 clk = ~clk;

  int_ctrl_8 dut (
    .clk(clk), .reset(reset), .irq(irq), .csN(csN), .rdN(rdN), .wrN(wrN),
    .addr(addr), .intaN(intaN), .intr(intr), .data(data)
  );

  function automatic int mSelect();
    int lim = 8;
    for (int i = 0; i < 8; i++) if (mIsr[i]) begin lim = i; break; end
    for (int i = 0; i < lim; i++) if (mIrr[i] && !mImr[i]) return i;
    return -1;
  endfunction

  function automatic logic mIntr();
    return mSelect() >= 0;
  endfunction

  function automatic logic [7:0] mAck();
    int s = mSelect();
    if (s >= 0) begin
      mIsr[s] = 1'b1;
      mIrr[s] = 1'b0;
      return {mBase, 3'(s)};
    end
    return {mBase, 3'd7};
  endfunction

  task automatic mEoi();
    for (int i = 0; i < 8; i++) if (mIsr[i]) begin mIsr[i] = 1'b0; break; end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; irq = '0; csN = 1'b1; rdN = 1'b1; wrN = 1'b1; addr = '0;
    intaN = 1'b1; dataOe = 1'b0; dataDrv = '0;
    tick(2);
    reset = 1'b0;
    mImr = 8'hFF; mIrr = '0; mIsr = '0; mBase = 5'b00010;
    tick(1);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
    addr = a; dataDrv = d; dataOe = 1'b1; csN = 1'b0; wrN = 1'b0;
    tick(3);
    csN = 1'b1; wrN = 1'b1; dataOe = 1'b0;
    tick(2);
    case (a)
      2'd0:    mImr = d;
      2'd1:    mBase = d[7:3];
      2'd3:    mEoi();
      default: ;
    endcase
  endtask

  task automatic busRead(input logic [1:0] a, output logic [7:0] d);
    addr = a; csN = 1'b0; rdN = 1'b0;
    #1 d = data;
    csN = 1'b1; rdN = 1'b1;
    #1;
  endtask

  task automatic pulseIrq(input logic [7:0] m);
    irq = m;
    tick(1);
    irq = '0;
    tick(5);
    mIrr = mIrr | m;
  endtask

  task automatic doAck(output logic [7:0] vec, output logic [7:0] rel, output logic ackIntr);
    intaN = 1'b0; tick(4);
    ackIntr = intr;
    intaN = 1'b1; tick(3);
    intaN = 1'b0; tick(4);
    vec = data;
    intaN = 1'b1;
    #1 rel = data;
    tick(3);
  endtask

  task automatic test_reset();
    logic [7:0] r;
    doReset();
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b expected 0", intr); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL reset_bus_idle: got %h expected ff", data); end
    busRead(2'd0, r);
    checks++; if (r !== 8'hFF) begin errors++; $display("FAIL reset_imr: got %h expected ff", r); end
    busRead(2'd1, r);
    checks++; if (r !== 8'h10) begin errors++; $display("FAIL reset_base: got %h expected 10", r); end
    busRead(2'd2, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_irr: got %h expected 00", r); end
    busRead(2'd3, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_isr: got %h expected 00", r); end
  endtask

  task automatic test_basic();
    logic [7:0] r, vec, rel, exp;
    logic ai;
    doReset();
    busWrite(2'd0, 8'hFE);
    irq = 8'h01; tick(1); irq = '0;
    tick(1);
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL lat_k1_intr: got %b expected 0", intr); end
    tick(1);
    busRead(2'd2, r);
    checks++; if (r !== 8'h01) begin errors++; $display("FAIL lat_k2_irr: got %h expected 01", r); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL lat_k2_intr: got %b expected 0", intr); end
    tick(1);
    mIrr = 8'h01;
    checks++; if (intr !== mIntr()) begin errors++; $display("FAIL lat_k3_intr: got %b expected %b", intr, mIntr()); end
    busWrite(2'd2, 8'hFF);
    busRead(2'd2, r);
    checks++; if (r !== mIrr) begin errors++; $display("FAIL irr_write_ignored: got %h expected %h", r, mIrr); end
    exp = mAck();
    doAck(vec, rel, ai);
    checks++; if (vec !== exp) begin errors++; $display("FAIL basic_vector: got %h expected %h", vec, exp); end
    checks++; if (ai !== 1'b0) begin errors++; $display("FAIL basic_intr_in_ack: got %b expected 0", ai); end
    checks++; if (rel !== 8'hFF) begin errors++; $display("FAIL basic_release: got %h expected ff", rel); end
    busRead(2'd3, r);
    checks++; if (r !== mIsr) begin errors++; $display("FAIL basic_isr: got %h expected %h", r, mIsr); end
    busRead(2'd2, r);
    checks++; if (r !== mIrr) begin errors++; $display("FAIL basic_irr: got %h expected %h", r, mIrr); end
    tick(4);
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL basic_intr_before_eoi: got %b expected 0", intr); end
    busWrite(2'd3, 8'h00);
    busRead(2'd3, r);
    checks++; if (r !== mIsr) begin errors++; $display("FAIL basic_isr_after_eoi: got %h expected %h", r, mIsr); end
  endtask

  task automatic test_priority();
    logic [7:0] r, vec, rel, exp;
    logic ai;
    doReset();
    busWrite(2'd0, 8'h00);
    busWrite(2'd1, 8'h40);
    pulseIrq(8'h24);
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL prio_intr: got %b expected 1", intr); end
    exp = mAck();
    doAck(vec, rel, ai);
    checks++; if (vec !== exp) begin errors++; $display("FAIL prio_vec1: got %h expected %h", vec, exp); end
    busRead(2'd3, r);
    checks++; if (r !== mIsr) begin errors++; $display("FAIL prio_isr1: got %h expected %h", r, mIsr); end
    busWrite(2'd3, 8'h00);
    checks++; if (intr !== mIntr()) begin errors++; $display("FAIL prio_reassert: got %b expected %b", intr, mIntr()); end
    exp = mAck();
    doAck(vec, rel, ai);
    checks++; if (vec !== exp) begin errors++; $display("FAIL prio_vec2: got %h expected %h", vec, exp); end
    busWrite(2'd3, 8'h00);
    busRead(2'd3, r);
    checks++; if (r !== mIsr) begin errors++; $display("FAIL prio_isr_clear: got %h expected %h", r, mIsr); end
  endtask

  task automatic test_nesting();
    logic [7:0] r, vec, rel, exp;
    logic ai;
    doReset();
    busWrite(2'd0, 8'h00);
    pulseIrq(8'h10);
    exp = mAck();
    doAck(vec, rel, ai);
    checks++; if (vec !== exp) begin errors++; $display("FAIL nest_vec4: got %h expected %h", vec, exp); end
    pulseIrq(8'h40);
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL nest_low_blocked: got %b expected 0", intr); end
    pulseIrq(8'h02);
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL nest_high_intr: got %b expected 1", intr); end
    exp = mAck();
    doAck(vec, rel, ai);
    checks++; if (vec !== exp) begin errors++; $display("FAIL nest_vec1: got %h expected %h", vec, exp); end
    busRead(2'd3, r);
    checks++; if (r !== 8'h12) begin errors++; $display("FAIL nest_isr: got %h expected 12", r); end
    busWrite(2'd3, 8'h00);
    busRead(2'd3, r);
    checks++; if (r !== mIsr) begin errors++; $display("FAIL nest_isr_eoi: got %h expected %h", r, mIsr); end
    busWrite(2'd3, 8'h00);
    checks++; if (intr !== mIntr()) begin errors++; $display("FAIL nest_low_released: got %b expected %b", intr, mIntr()); end
  endtask

  task automatic test_spurious();
    logic [7:0] r, vec, rel, exp;
    logic ai;
    doReset();
    busWrite(2'd0, 8'h00);
    pulseIrq(8'h08);
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL spur_intr: got %b expected 1", intr); end
    busWrite(2'd0, 8'h08);
    exp = mAck();
    doAck(vec, rel, ai);
    checks++; if (vec !== exp) begin errors++; $display("FAIL spur_vec: got %h expected %h", vec, exp); end
    busRead(2'd3, r);
    checks++; if (r !== mIsr) begin errors++; $display("FAIL spur_isr: got %h expected %h", r, mIsr); end
    busRead(2'd2, r);
    checks++; if (r !== 8'h08) begin errors++; $display("FAIL spur_irr: got %h expected 08", r); end
  endtask

  task automatic test_held_write();
    logic [7:0] r, vec, rel, exp;
    logic ai;
    doReset();
    busWrite(2'd0, 8'h00);
    pulseIrq(8'h04);
    exp = mAck(); doAck(vec, rel, ai);
    pulseIrq(8'h01);
    exp = mAck(); doAck(vec, rel, ai);
    busRead(2'd3, r);
    checks++; if (r !== 8'h05) begin errors++; $display("FAIL held_isr_pre: got %h expected 05", r); end
    addr = 2'd3; dataDrv = 8'h00; dataOe = 1'b1; csN = 1'b0; wrN = 1'b0;
    tick(10);
    csN = 1'b1; wrN = 1'b1; dataOe = 1'b0;
    tick(2);
    mEoi();
    busRead(2'd3, r);
    checks++; if (r !== mIsr) begin errors++; $display("FAIL held_single_eoi: got %h expected %h", r, mIsr); end
  endtask

  task automatic test_level();
    logic [7:0] r, vec, rel, exp;
    logic ai;
    doReset();
    busWrite(2'd0, 8'h00);
    irq = 8'h04;
    tick(8);
    mIrr = 8'h04;
    exp = mAck();
    doAck(vec, rel, ai);
    checks++; if (vec !== exp) begin errors++; $display("FAIL level_vec: got %h expected %h", vec, exp); end
    busWrite(2'd3, 8'h00);
    tick(8);
    busRead(2'd2, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL level_single_req: got %h expected 00", r); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL level_intr: got %b expected 0", intr); end
    irq = '0;
    tick(4);
  endtask

  task automatic test_reset_mid_ack();
    logic [7:0] r;
    doReset();
    busWrite(2'd0, 8'hFE);
    pulseIrq(8'h01);
    intaN = 1'b0; tick(4);
    intaN = 1'b1; tick(3);
    reset = 1'b1;
    tick(2);
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_mid_intr: got %b expected 0", intr); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL rst_mid_bus: got %h expected ff", data); end
    reset = 1'b0;
    mImr = 8'hFF; mIrr = '0; mIsr = '0; mBase = 5'b00010;
    tick(1);
    busRead(2'd0, r);
    checks++; if (r !== mImr) begin errors++; $display("FAIL rst_mid_imr: got %h expected %h", r, mImr); end
    busRead(2'd1, r);
    checks++; if (r !== {mBase, 3'b000}) begin errors++; $display("FAIL rst_mid_base: got %h expected %h", r, {mBase, 3'b000}); end
    intaN = 1'b0; tick(4);
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL rst_mid_no_vector: got %h expected ff", data); end
    intaN = 1'b1; tick(3);
    busRead(2'd3, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL rst_mid_isr: got %h expected 00", r); end
    reset = 1'b1; irq = 8'h08;
    tick(3);
    reset = 1'b0;
    tick(8);
    busRead(2'd2, r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL rst_held_irq: got %h expected 00", r); end
    irq = '0;
    doReset();
  endtask

  task automatic test_random();
    logic [7:0] r, vec, rel, exp;
    logic ai;
    doReset();
    busWrite(2'd1, 8'h80);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: pulseIrq(8'($urandom_range(0, 255) & $urandom_range(0, 255)));
        1: busWrite(2'd0, 8'($urandom_range(0, 255) & $urandom_range(0, 255)));
        2: if (mIntr()) begin
             exp = mAck();
             doAck(vec, rel, ai);
             checks++; if (vec !== exp) begin errors++; $display("FAIL rnd_vec it%0d: got %h expected %h", it, vec, exp); end
             checks++; if (rel !== 8'hFF) begin errors++; $display("FAIL rnd_release it%0d: got %h expected ff", it, rel); end
           end
        default: busWrite(2'd3, 8'h00);
      endcase
      checks++; if (intr !== mIntr()) begin errors++; $display("FAIL rnd_intr it%0d: got %b expected %b", it, intr, mIntr()); end
      busRead(2'd2, r);
      checks++; if (r !== mIrr) begin errors++; $display("FAIL rnd_irr it%0d: got %h expected %h", it, r, mIrr); end
      busRead(2'd3, r);
      checks++; if (r !== mIsr) begin errors++; $display("FAIL rnd_isr it%0d: got %h expected %h", it, r, mIsr); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_nesting();
    test_spurious();
    test_held_write();
    test_level();
    test_reset_mid_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
